audio_sample_buffer: RTL and testbench

AUDIO_SAMPLE_BUFFER -- requirements
Module: audio_sample_buffer

---
 rtl/audio_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/audio_sample_buffer.sv | 105 ++++++++++
 tb/tb_audio_sample_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample buffer: playback state
// encoding and the keyboard scan codes that select a state.
package audio_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        PLAY = 2'd1,
        MUTE = 2'd2
    } state_t;

    localparam logic [7:0] KEY_STOP = 8'h23;
    localparam logic [7:0] KEY_PLAY = 8'h24;
    localparam logic [7:0] KEY_MUTE = 8'h2B;

    // Map a scan code to the state it selects; unrecognised codes keep the
    // current state.
    function automatic state_t decode_key(input logic [7:0] key, input state_t cur);
        case (key)
            KEY_STOP: return STOP;
            KEY_PLAY: return PLAY;
            KEY_MUTE: return MUTE;
            default:  return cur;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush. Push while full is ignored
// unless a pop happens on the same edge, in which case both take effect.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame storage write port.
    // NOTE: storage is deliberately not reset; occupancy gates every read, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/audio_sample_buffer.sv
// Audio sample buffer: detects the rising edge of the sample-rate strobe,
// runs the STOP/PLAY/MUTE key FSM, feeds captured frames through sync_fifo
// and counts frames dropped on overflow.
module audio_sample_buffer
    import audio_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                     clock50,
    input  logic                     rstn,
    input  logic                     synced_sig,
    input  logic [NUM_CH*DATA_W-1:0] getdata,
    input  logic [7:0]               key_control,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] pass_data_audio,
    output logic                     confirm_pass,
    output logic                     playing,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [CNT_W-1:0]         overflow_cnt
);

    localparam int FW = NUM_CH * DATA_W;

    logic          r_sig_d;
    logic          w_capture;
    state_t        r_state;
    state_t        w_next_state;
    logic          w_accept;
    logic          w_flush;
    logic [FW-1:0] w_frame;
    logic [FW-1:0] w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_valid;
    logic          w_pop;
    logic          w_drop;
    logic [CNT_W-1:0] r_overflow_cnt;

    // One capture event per strobe, however long it stays high.
    assign w_capture = synced_sig && !r_sig_d;

    // Registered copy of the strobe for edge detection.
    always_ff @(posedge clock50 or negedge rstn) begin
        if (!rstn) r_sig_d <= 1'b0;
        else       r_sig_d <= synced_sig;
    end

    // Playback state register.
    always_ff @(posedge clock50 or negedge rstn) begin
        if (!rstn) r_state <= STOP;
        else       r_state <= w_next_state;
    end

    // Next state from the key; capture handling follows the current (old) state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_next_state = decode_key(key_control, r_state);
        w_accept     = 1'b0;
        w_frame      = getdata;
        case (r_state)
            PLAY:    w_accept = w_capture;
            MUTE: begin
                w_accept = w_capture;
                w_frame  = '0;
            end
            default: w_accept = 1'b0;
        endcase
        // Entering (or staying in) STOP empties the buffer.
        w_flush = (w_next_state == STOP);
    end

    assign w_valid         = !w_empty && (r_state != STOP);
    assign w_pop           = w_valid && out_ready;
    assign w_drop          = w_accept && w_full && !w_pop;
    assign confirm_pass    = w_valid;
    assign playing         = (r_state != STOP);
    assign pass_data_audio = w_valid ? w_head : '0;
    assign overflow_cnt    = r_overflow_cnt;

    // Saturating count of frames dropped because the buffer was full.
    always_ff @(posedge clock50 or negedge rstn) begin
        if (!rstn)                              r_overflow_cnt <= '0;
        else if (w_drop && !(&r_overflow_cnt))  r_overflow_cnt <= r_overflow_cnt + 1'b1;
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock50),
        .rst_n   (rstn),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (w_frame),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fill_level)
    );

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Self-checking bench for audio_sample_buffer: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_audio_sample_buffer;

    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;
    localparam int OVF_MAX = (1 << CNT_W) - 1;

    logic        clock50 = 1'b0;
    logic        rstn = 1'b1;
    logic        synced_sig = 1'b0;
    logic [31:0] getdata = '0;
    logic [7:0]  key_control = '0;
    logic        out_ready = 1'b0;
    logic [31:0] pass_data_audio;
    logic        confirm_pass;
    logic        playing;
    logic [2:0]  fill_level;
    logic [CNT_W-1:0] overflow_cnt;

    audio_sample_buffer #(
        .DATA_W (16),
        .NUM_CH (2),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clock50         (clock50),
        .rstn            (rstn),
        .synced_sig      (synced_sig),
        .getdata         (getdata),
        .key_control     (key_control),
        .out_ready       (out_ready),
        .pass_data_audio (pass_data_audio),
        .confirm_pass    (confirm_pass),
        .playing         (playing),
        .fill_level      (fill_level),
        .overflow_cnt    (overflow_cnt)
    );

    always #5 clock50 = ~clock50;

    // Reference model: 0 = stopped, 1 = playing, 2 = muted.
    int          m_mode;
    logic [31:0] m_q[$];
    int          m_ovf;
    logic        m_prev;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_q.delete();
        m_ovf  = 0;
        m_prev = 1'b0;
    endtask

    // Apply one clock edge's worth of behaviour using the inputs currently driven.
    task automatic model_edge();
        bit cap, valid, pop, was_full;
        int nxt;
        cap      = synced_sig && !m_prev;
        valid    = (m_q.size() > 0) && (m_mode != 0);
        pop      = valid && out_ready;
        was_full = (m_q.size() == DEPTH);
        nxt      = m_mode;
        if (key_control == 8'h23)      nxt = 0;
        else if (key_control == 8'h24) nxt = 1;
        else if (key_control == 8'h2B) nxt = 2;
        if (pop) void'(m_q.pop_front());
        if (cap && m_mode != 0) begin
            if (was_full && !pop) begin
                if (m_ovf < OVF_MAX) m_ovf++;
            end else begin
                m_q.push_back(m_mode == 2 ? 32'h0 : getdata);
            end
        end
        if (nxt == 0) m_q.delete();
        m_mode = nxt;
        m_prev = synced_sig;
    endtask

    task automatic check_outputs(input string where);
        bit v;
        v = (m_q.size() > 0) && (m_mode != 0);
        check({where, ":confirm"}, 64'(confirm_pass), 64'(v));
        check({where, ":data"},    64'(pass_data_audio), v ? 64'(m_q[0]) : 64'h0);
        check({where, ":fill"},    64'(fill_level), 64'(m_q.size()));
        check({where, ":playing"}, 64'(playing), 64'(m_mode != 0));
        check({where, ":ovf"},     64'(overflow_cnt), 64'(m_ovf));
    endtask

    task automatic cycle(input logic sig, input logic [31:0] data, input logic [7:0] key,
                         input logic rdy, input string tag);
        synced_sig  = sig;
        getdata     = data;
        key_control = key;
        out_ready   = rdy;
        @(posedge clock50);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] k;
        int r;
        model_reset();

        // Power-on reset state.
        #1 rstn = 1'b0;
        #1 check_outputs("reset");
        repeat (2) @(negedge clock50);
        rstn = 1'b1;

        // Held strobe in PLAY yields exactly one frame, one cycle after the edge.
        cycle(1'b0, 32'h0, 8'h24, 1'b1, "key_play");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'hAAAA_5555, 8'h00, 1'b1, "hold_strobe");
            if (i == 0) begin
                check("first_valid", 64'(confirm_pass), 64'd1);
                check("first_data", 64'(pass_data_audio), 64'hAAAA_5555);
            end
            if (i == 1) check("single_frame", 64'(confirm_pass), 64'd0);
        end
        cycle(1'b0, 32'h0, 8'h00, 1'b1, "strobe_low");

        // Six edges with the sink stalled: four stored, two dropped.
        for (int e = 0; e < 6; e++) begin
            cycle(1'b1, 32'h1000_0000 + 32'(e), 8'h00, 1'b0, "fill_hi");
            cycle(1'b0, 32'h0, 8'h00, 1'b0, "fill_lo");
        end
        check("full_level", 64'(fill_level), 64'd4);
        check("full_ovf", 64'(overflow_cnt), 64'd2);
        check("full_head", 64'(pass_data_audio), 64'h1000_0000);

        // Capture and pop together while full: no drop, level unchanged.
        cycle(1'b1, 32'h2000_0000, 8'h00, 1'b1, "push_pop_full");
        check("pp_level", 64'(fill_level), 64'd4);
        check("pp_ovf", 64'(overflow_cnt), 64'd2);
        check("pp_head", 64'(pass_data_audio), 64'h1000_0001);
        cycle(1'b0, 32'h0, 8'h00, 1'b0, "pp_idle");
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 8'h00, 1'b1, "drain");

        // MUTE writes silence but still presents a frame.
        cycle(1'b0, 32'h0, 8'h2B, 1'b0, "key_mute");
        cycle(1'b1, 32'h1234_5678, 8'h00, 1'b0, "mute_cap");
        check("mute_data", 64'(pass_data_audio), 64'h0);
        check("mute_valid", 64'(confirm_pass), 64'd1);
        check("mute_playing", 64'(playing), 64'd1);
        cycle(1'b0, 32'h0, 8'h00, 1'b1, "mute_pop");

        // STOP flushes buffered frames and ignores later strobes.
        cycle(1'b0, 32'h0, 8'h24, 1'b0, "replay");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, $urandom, 8'h00, 1'b0, "buf3_hi");
            cycle(1'b0, 32'h0, 8'h00, 1'b0, "buf3_lo");
        end
        check("buf3_level", 64'(fill_level), 64'd3);
        cycle(1'b0, 32'h0, 8'h23, 1'b0, "key_stop");
        check("stop_valid", 64'(confirm_pass), 64'd0);
        check("stop_level", 64'(fill_level), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, $urandom, 8'h00, 1'b1, "stop_hi");
            cycle(1'b0, 32'h0, 8'h00, 1'b1, "stop_lo");
        end
        check("stop_ignored", 64'(fill_level), 64'd0);

        // Overflow counter saturates.
        cycle(1'b0, 32'h0, 8'h24, 1'b0, "sat_play");
        for (int i = 0; i < 13; i++) begin
            cycle(1'b1, 32'h3000_0000 + 32'(i), 8'h00, 1'b0, "sat_hi");
            cycle(1'b0, 32'h0, 8'h00, 1'b0, "sat_lo");
        end
        check("sat_ovf", 64'(overflow_cnt), 64'(OVF_MAX));

        // Asynchronous reset in the middle of a transfer.
        cycle(1'b1, 32'h0, 8'h00, 1'b1, "pre_rst");
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        check("arst_valid", 64'(confirm_pass), 64'd0);
        check("arst_ovf", 64'(overflow_cnt), 64'd0);
        @(negedge clock50);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 8'h00, 1'b1, "post_rst");
        cycle(1'b0, 32'h0, 8'h24, 1'b1, "post_rst_play");
        cycle(1'b0, 32'h0, 8'h00, 1'b1, "post_rst_idle");
        check("post_rst_empty", 64'(confirm_pass), 64'd0);
        cycle(1'b1, 32'hCAFE_F00D, 8'h00, 1'b0, "post_rst_cap");
        check("post_rst_frame", 64'(pass_data_audio), 64'hCAFE_F00D);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 19));
            case (r)
                0:       k = 8'h23;
                1, 2:    k = 8'h24;
                3:       k = 8'h2B;
                4: begin
                    k = 8'($urandom);
                    if (k == 8'h23 || k == 8'h24 || k == 8'h2B) k = 8'h00;
                end
                default: k = 8'h00;
            endcase
            cycle(1'($urandom), $urandom, k, 1'($urandom_range(0, 2) == 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
